// File: rtl/parking_gate_ctrl.sv
// Entry-gate controller: PIN check with attempt lockout, tailgate blocking,
// occupancy tracking with capacity-gated admission, and an open-gate timeout.
module parking_gate_ctrl #(
    parameter int                  PW_WIDTH     = 8,
    parameter logic [PW_WIDTH-1:0] PASSWORD     = 87,
    parameter int                  MAX_ATTEMPTS = 3,
    parameter int                  CAPACITY     = 16,
    parameter int                  GATE_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sensor_arrive,
    input  logic                           sensor_enter,
    input  logic                           sensor_exit,
    input  logic                           try_psswrd,
    input  logic [PW_WIDTH-1:0]            psswrd_atmpt,
    output logic                           open_gate,
    output logic                           close_gate,
    output logic                           alarm_pin,
    output logic                           alarm_block,
    output logic                           full,
    output logic [$clog2(CAPACITY+1)-1:0]  occupancy
);

    localparam int OW = $clog2(CAPACITY + 1);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int TW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;

    localparam logic [OW-1:0] OCC_MAX  = OW'(CAPACITY);
    localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);
    localparam logic [TW-1:0] TIME_MAX = TW'(GATE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PIN,
        OPEN,
        BLOCK
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] attempts, attempts_n;
    logic [TW-1:0] timer, timer_n;
    logic [OW-1:0] occupancy_n;
    logic          open_n, close_n, alarm_pin_n, alarm_block_n;
    logic          try_prev, exit_prev;
    logic          submit, exit_event, correct, collision, car_in;

    assign submit     = try_psswrd && !try_prev;
    assign exit_event = sensor_exit && !exit_prev;
    assign correct    = submit && (psswrd_atmpt == PASSWORD);
    assign collision  = sensor_arrive && sensor_enter;
    assign full       = (occupancy == OCC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            attempts    <= '0;
            timer       <= '0;
            occupancy   <= '0;
            open_gate   <= 1'b0;
            close_gate  <= 1'b0;
            alarm_pin   <= 1'b0;
            alarm_block <= 1'b0;
            try_prev    <= 1'b0;
            exit_prev   <= 1'b0;
        end else begin
            state       <= state_n;
            attempts    <= attempts_n;
            timer       <= timer_n;
            occupancy   <= occupancy_n;
            open_gate   <= open_n;
            close_gate  <= close_n;
            alarm_pin   <= alarm_pin_n;
            alarm_block <= alarm_block_n;
            try_prev    <= try_psswrd;
            exit_prev   <= sensor_exit;
        end
    end

    // A collision outranks every other condition outside BLOCK.
    always_comb begin
        state_n       = state;
        attempts_n    = attempts;
        timer_n       = timer;
        open_n        = open_gate;
        close_n       = 1'b0;
        alarm_pin_n   = alarm_pin;
        alarm_block_n = alarm_block;
        car_in        = 1'b0;

        if (collision && state != BLOCK) begin
            state_n       = BLOCK;
            alarm_block_n = 1'b1;
            open_n        = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sensor_arrive && !full) begin
                        state_n = PIN;
                    end
                end
                PIN: begin
                    if (correct) begin
                        state_n     = OPEN;
                        open_n      = 1'b1;
                        attempts_n  = '0;
                        alarm_pin_n = 1'b0;
                        timer_n     = '0;
                    end else if (submit) begin
                        attempts_n = (attempts == ATT_MAX) ? attempts : attempts + AW'(1);
                        if (attempts_n == ATT_MAX) begin
                            alarm_pin_n = 1'b1;
                        end
                    end else if (!sensor_arrive) begin
                        state_n     = IDLE;
                        attempts_n  = '0;
                        alarm_pin_n = 1'b0;
                    end
                end
                OPEN: begin
                    if (sensor_enter) begin
                        state_n = IDLE;
                        open_n  = 1'b0;
                        close_n = 1'b1;
                        car_in  = 1'b1;
                    end else if (timer == TIME_MAX) begin
                        state_n = IDLE;
                        open_n  = 1'b0;
                        close_n = 1'b1;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
                BLOCK: begin
                    open_n = 1'b0;
                    if (correct) begin
                        state_n       = IDLE;
                        alarm_block_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Simultaneous entry and exit cancel out.
    always_comb begin
        occupancy_n = occupancy;
        if (car_in && exit_event) begin
            occupancy_n = occupancy;
        end else if (car_in && occupancy != OCC_MAX) begin
            occupancy_n = occupancy + OW'(1);
        end else if (exit_event && occupancy != '0) begin
            occupancy_n = occupancy - OW'(1);
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed test-plan scenarios with literal checks,
// then randomized traffic compared every cycle against a behavioural model.
module tb_parking_gate_ctrl;

    localparam int            CAP  = 2;
    localparam int            GT   = 8;
    localparam int            MAXA = 3;
    localparam logic [7:0]    PASS = 8'd87;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_arrive, sensor_enter, sensor_exit, try_psswrd;
    logic [7:0] psswrd_atmpt;
    logic       open_gate, close_gate, alarm_pin, alarm_block, full;
    logic [1:0] occupancy;

    int compared   = 0;
    int mismatched = 0;

    parking_gate_ctrl #(
        .PW_WIDTH    (8),
        .PASSWORD    (PASS),
        .MAX_ATTEMPTS(MAXA),
        .CAPACITY    (CAP),
        .GATE_TIMEOUT(GT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_arrive(sensor_arrive),
        .sensor_enter (sensor_enter),
        .sensor_exit  (sensor_exit),
        .try_psswrd   (try_psswrd),
        .psswrd_atmpt (psswrd_atmpt),
        .open_gate    (open_gate),
        .close_gate   (close_gate),
        .alarm_pin    (alarm_pin),
        .alarm_block  (alarm_block),
        .full         (full),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    // Behavioural model: lane phase as a word, counts as plain integers.
    string mode = "idle";
    int    tries = 0, cars = 0, step = 0, open_since = 0;
    bit    m_gate = 0, m_close = 0, m_pin_alarm = 0, m_blk_alarm = 0;
    bit    last_try = 0, last_exit = 0;

    task automatic model_step();
        bit submit, leave, good, clash;
        int delta;
        step++;
        if (rst) begin
            mode = "idle"; tries = 0; cars = 0;
            m_gate = 0; m_close = 0; m_pin_alarm = 0; m_blk_alarm = 0;
            last_try = 0; last_exit = 0;
        end else begin
            submit  = try_psswrd && !last_try;
            leave   = sensor_exit && !last_exit;
            good    = submit && (psswrd_atmpt == PASS);
            clash   = sensor_arrive && sensor_enter;
            delta   = 0;
            m_close = 0;
            if (clash && mode != "block") begin
                mode = "block"; m_blk_alarm = 1; m_gate = 0;
            end else if (mode == "idle") begin
                if (sensor_arrive && cars < CAP) mode = "pin";
            end else if (mode == "pin") begin
                if (good) begin
                    mode = "open"; m_gate = 1; tries = 0; m_pin_alarm = 0; open_since = step;
                end else if (submit) begin
                    tries = (tries + 1 > MAXA) ? MAXA : tries + 1;
                    if (tries == MAXA) m_pin_alarm = 1;
                end else if (!sensor_arrive) begin
                    mode = "idle"; tries = 0; m_pin_alarm = 0;
                end
            end else if (mode == "open") begin
                if (sensor_enter) begin
                    mode = "idle"; m_gate = 0; m_close = 1; delta = 1;
                end else if (step - open_since == GT) begin
                    mode = "idle"; m_gate = 0; m_close = 1;
                end
            end else begin
                if (good) begin
                    mode = "idle"; m_blk_alarm = 0;
                end
            end
            if (leave) delta = delta - 1;
            if (delta > 0 && cars < CAP) cars++;
            else if (delta < 0 && cars > 0) cars--;
            last_try  = try_psswrd;
            last_exit = sensor_exit;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        checkOutput("open_gate",   int'(open_gate),   int'(m_gate));
        checkOutput("close_gate",  int'(close_gate),  int'(m_close));
        checkOutput("alarm_pin",   int'(alarm_pin),   int'(m_pin_alarm));
        checkOutput("alarm_block", int'(alarm_block), int'(m_blk_alarm));
        checkOutput("full",        int'(full),        int'(cars == CAP));
        checkOutput("occupancy",   int'(occupancy),   cars);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit a, input bit e, input bit x, input bit t, input logic [7:0] p);
        sensor_arrive = a;
        sensor_enter  = e;
        sensor_exit   = x;
        try_psswrd    = t;
        psswrd_atmpt  = p;
        tick();
    endtask

    task automatic submitPin(input bit a, input logic [7:0] p);
        applyStimulus(a, 0, 0, 1, p);
    endtask

    int open_cycles;

    initial begin
        rst = 1; sensor_arrive = 0; sensor_enter = 0; sensor_exit = 0;
        try_psswrd = 0; psswrd_atmpt = 0;
        tick(); tick();
        checkOutput("reset open_gate", int'(open_gate), 0);
        checkOutput("reset occupancy", int'(occupancy), 0);
        rst = 0;
        tick();

        // Normal entry
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, PASS);
        checkOutput("entry open_gate", int'(open_gate), 1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("entry close_gate", int'(close_gate), 1);
        checkOutput("entry occupancy", int'(occupancy), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("close pulse ends", int'(close_gate), 0);

        // Lockout
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, 8'd5); applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, 8'd6); applyStimulus(1, 0, 0, 0, 0);
        checkOutput("two wrong alarm_pin", int'(alarm_pin), 0);
        submitPin(1, 8'd7);
        checkOutput("third wrong alarm_pin", int'(alarm_pin), 1);
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, 8'd8); applyStimulus(1, 0, 0, 0, 0);
        checkOutput("fourth wrong alarm_pin", int'(alarm_pin), 1);
        submitPin(1, PASS);
        checkOutput("unlock alarm_pin", int'(alarm_pin), 0);
        checkOutput("unlock open_gate", int'(open_gate), 1);

        // Tailgate in OPEN
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("tailgate alarm_block", int'(alarm_block), 1);
        checkOutput("tailgate open_gate", int'(open_gate), 0);
        applyStimulus(0, 0, 0, 0, 0);
        submitPin(0, 8'd12); applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrong pin keeps block", int'(alarm_block), 1);
        submitPin(0, PASS); applyStimulus(0, 0, 0, 0, 0);
        checkOutput("correct pin clears block", int'(alarm_block), 0);

        // Capacity
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, PASS);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("second entry occupancy", int'(occupancy), 2);
        checkOutput("second entry full", int'(full), 1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, PASS);
        checkOutput("full lot gate stays shut", int'(open_gate), 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("exit occupancy", int'(occupancy), 1);
        checkOutput("exit full", int'(full), 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Timeout
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, PASS);
        open_cycles = int'(open_gate);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && open_gate; i++) begin
            open_cycles++;
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("timeout open cycles", open_cycles, GT);
        checkOutput("timeout close_gate", int'(close_gate), 1);
        checkOutput("timeout occupancy", int'(occupancy), 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Entry and exit together
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, PASS);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("enter+exit occupancy", int'(occupancy), 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset mid-OPEN
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, PASS);
        rst = 1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mid reset open_gate", int'(open_gate), 0);
        checkOutput("mid reset occupancy", int'(occupancy), 0);
        rst = 0;

        // Held submit counts once
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) submitPin(1, 8'd5);
        applyStimulus(1, 0, 0, 0, 0);
        submitPin(1, 8'd6); applyStimulus(1, 0, 0, 0, 0);
        checkOutput("held try counted once", int'(alarm_pin), 0);
        submitPin(1, 8'd7); applyStimulus(1, 0, 0, 0, 0);
        checkOutput("held try third attempt", int'(alarm_pin), 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            sensor_arrive = ($urandom_range(0, 1) == 1);
            sensor_enter  = ($urandom_range(0, 3) == 0);
            sensor_exit   = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 9) < 4) try_psswrd = ~try_psswrd;
            psswrd_atmpt  = ($urandom_range(0, 9) < 4) ? PASS : 8'($urandom_range(0, 255));
            tick();
        end
        rst = 0;
        applyStimulus(0, 0, 0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
